// File: rtl/axis_ip_pkg.sv
// Shared types and constants for the AXI-Stream IPv4 header/length checker.
package axis_ip_pkg;

    typedef enum logic [1:0] {
        HDR,
        PAY,
        STAT
    } state_t;

    localparam int unsigned ERR_RUNT = 0;
    localparam int unsigned ERR_VER  = 1;
    localparam int unsigned ERR_CSUM = 2;
    localparam int unsigned ERR_LEN  = 3;
    localparam int unsigned ERR_STRB = 4;

    localparam logic [3:0] IPV4_VER = 4'd4;
    localparam logic [3:0] IHL_MIN  = 4'd5;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/axis_ip_pkt_chk_if.sv
// AXI-Stream beat bus carrying packets into the IPv4 checker.
interface axis_ip_pkt_chk_if;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tstrb, tlast, tvalid, input tready);
    modport slave  (input tdata, tstrb, tlast, tvalid, output tready);
endinterface

// File: rtl/ip_csum_acc.sv
// 32-bit ones-complement accumulator over two halfwords per beat, folded to 16 bits.
module ip_csum_acc (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        add,
    input  logic        clear,
    input  logic [31:0] data,
    output logic [15:0] sum
);
    logic [31:0] acc_q;
    logic [31:0] acc_next;
    logic [16:0] fold1;

    always_comb begin
        acc_next = acc_q;
        if (add)
            acc_next = acc_q + {16'h0000, data[31:16]} + {16'h0000, data[15:0]};
    end

    // The fold includes the beat being added this cycle, so the last header
    // beat can be judged in the same cycle it is accepted.
    always_comb begin
        fold1 = {1'b0, acc_next[31:16]} + {1'b0, acc_next[15:0]};
        sum   = fold1[15:0] + {15'h0000, fold1[16]};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            acc_q <= '0;
        else if (clear)
            acc_q <= '0;
        else if (add)
            acc_q <= acc_next;
    end
endmodule

// File: rtl/axis_ip_pkt_chk.sv
// IPv4 packet checker on an AXI-Stream input: header checksum, version/IHL,
// length and strobe checks with per-packet status and running counters.
module axis_ip_pkt_chk
    import axis_ip_pkg::*;
#(
    parameter int          CNT_W     = 32,
    parameter logic [15:0] MAX_BYTES = 16'd65535
) (
    input  logic              aclk,
    input  logic              aresetn,
    axis_ip_pkt_chk_if.slave  S_AXIS,
    output logic              stat_valid,
    output logic [4:0]        stat_err,
    output logic [15:0]       stat_len,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    state_t      state_q, state_d;
    logic        ready_en_q;
    logic [3:0]  beat_idx_q, hdr_len_q;
    logic [15:0] tot_len_q, byte_cnt_q;
    logic        ver_err_q, csum_err_q, strb_err_q;

    logic        tready, accept, first, ver_bad_now, hdr_last, runt, strb_ok;
    logic [3:0]  hdr_len_cur;
    logic [15:0] tot_len_cur, byte_next, csum_sum;
    logic [16:0] byte_sum;
    logic        ver_err_cur, csum_err_cur, strb_err_cur;
    logic [4:0]  err_now;

    ip_csum_acc u_csum (
        .aclk    (aclk),
        .aresetn (aresetn),
        .add     (accept && (state_q == HDR)),
        .clear   (state_q == STAT),
        .data    (S_AXIS.tdata),
        .sum     (csum_sum)
    );

    assign S_AXIS.tready = tready;

    always_comb begin
        state_d    = state_q;
        tready     = ready_en_q && (state_q != STAT);
        stat_valid = (state_q == STAT);
        accept     = S_AXIS.tvalid && tready;
        unique case (state_q)
            HDR:  if (accept && S_AXIS.tlast) state_d = STAT;
                  else if (accept && hdr_last) state_d = PAY;
            PAY:  if (accept && S_AXIS.tlast) state_d = STAT;
            STAT: state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    // Beat-0 fields are used live so a one-beat packet sees its own header.
    always_comb begin
        first        = (state_q == HDR) && (beat_idx_q == 4'd0);
        ver_bad_now  = (S_AXIS.tdata[31:28] != IPV4_VER) || (S_AXIS.tdata[27:24] < IHL_MIN);
        hdr_len_cur  = first ? (ver_bad_now ? IHL_MIN : S_AXIS.tdata[27:24]) : hdr_len_q;
        ver_err_cur  = first ? ver_bad_now : ver_err_q;
        tot_len_cur  = first ? S_AXIS.tdata[15:0] : tot_len_q;
        hdr_last     = (state_q == HDR) && (beat_idx_q == hdr_len_cur - 4'd1);
        runt         = (state_q == HDR) && S_AXIS.tlast && !hdr_last;
        csum_err_cur = hdr_last ? (csum_sum != 16'hFFFF) : csum_err_q;
        byte_sum     = {1'b0, byte_cnt_q} + {14'h0000, popcount4(S_AXIS.tstrb)};
        byte_next    = (byte_sum > {1'b0, MAX_BYTES}) ? MAX_BYTES : byte_sum[15:0];
        if (S_AXIS.tlast)
            strb_ok = (S_AXIS.tstrb == 4'b1111) || (S_AXIS.tstrb == 4'b1110) ||
                      (S_AXIS.tstrb == 4'b1100) || (S_AXIS.tstrb == 4'b1000);
        else
            strb_ok = (S_AXIS.tstrb == 4'b1111);
        strb_err_cur       = strb_err_q || !strb_ok;
        err_now            = '0;
        err_now[ERR_RUNT]  = runt;
        err_now[ERR_VER]   = ver_err_cur;
        err_now[ERR_CSUM]  = !runt && csum_err_cur;
        err_now[ERR_LEN]   = !runt && (byte_next != tot_len_cur);
        err_now[ERR_STRB]  = strb_err_cur;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state_q <= HDR;
        else
            state_q <= state_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
            beat_idx_q <= '0;
            hdr_len_q  <= '0;
            tot_len_q  <= '0;
            byte_cnt_q <= '0;
            ver_err_q  <= 1'b0;
            csum_err_q <= 1'b0;
            strb_err_q <= 1'b0;
            stat_err   <= '0;
            stat_len   <= '0;
            pkt_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (state_q == STAT) begin
                beat_idx_q <= '0;
                byte_cnt_q <= '0;
                ver_err_q  <= 1'b0;
                csum_err_q <= 1'b0;
                strb_err_q <= 1'b0;
                pkt_cnt    <= pkt_cnt + CNT_W'(1);
                if (stat_err != '0)
                    err_cnt <= err_cnt + CNT_W'(1);
            end else if (accept) begin
                byte_cnt_q <= byte_next;
                strb_err_q <= strb_err_cur;
                if (state_q == HDR) begin
                    beat_idx_q <= beat_idx_q + 4'd1;
                    if (first) begin
                        hdr_len_q <= hdr_len_cur;
                        ver_err_q <= ver_err_cur;
                        tot_len_q <= tot_len_cur;
                    end
                    if (hdr_last)
                        csum_err_q <= csum_err_cur;
                end
                if (S_AXIS.tlast) begin
                    stat_err <= err_now;
                    stat_len <= byte_next;
                end
            end
        end
    end
endmodule
